// File: rtl/mem_resp_ctrl_pkg.sv
// rtl/mem_resp_ctrl_pkg.sv - shared encodings and request legality rule for the memory response controller
package mem_resp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        TGT_RAM = 1'b0,
        TGT_ROM = 1'b1
    } tgt_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int CNT_W = 4;

    // ROM is read-only, and the decoder must pick exactly one target.
    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic ram_sel, input logic rom_sel);
        return (rd && wr) || (ram_sel == rom_sel) || (wr && rom_sel);
    endfunction

endpackage

// File: rtl/mem_resp_ctrl_wait_cnt.sv
// rtl/mem_resp_ctrl_wait_cnt.sv - 4-bit loadable wait-state down-counter
module mem_resp_ctrl_wait_cnt
    import mem_resp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_resp_ctrl.sv
// rtl/mem_resp_ctrl.sv - CPU-facing RAM/ROM access controller with wait states, ready pulse and bus error
module mem_resp_ctrl
    import mem_resp_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int RAM_WAIT = 0,
    parameter int ROM_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ram_sel,
    input  logic              rom_sel,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              ram_ena,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rom_ena,
    output logic              rom_read,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] RAM_WAIT_C = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] ROM_WAIT_C = CNT_W'(ROM_WAIT);

    state_t state, state_nxt;
    tgt_t   tgt_q;
    op_t    op_q;
    logic   err_q;
    logic   req, illegal, accept;
    logic   cnt_load, cnt_dec, cnt_zero, capture;

    assign req     = cpu_rd || cpu_wr;
    assign illegal = req_illegal(cpu_rd, cpu_wr, ram_sel, rom_sel);
    assign accept  = (state == IDLE) && req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_load  = 1'b1;
                    state_nxt = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    capture   = (op_q == OP_RD);
                    state_nxt = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mem_resp_ctrl_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (rom_sel ? ROM_WAIT_C : RAM_WAIT_C),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Request is latched so that addr/sel wiggles during ACCESS cannot disturb the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            op_q      <= OP_RD;
            tgt_q     <= TGT_RAM;
            err_q     <= 1'b0;
        end else if (accept) begin
            mem_addr  <= addr;
            mem_wdata <= cpu_wdata;
            op_q      <= cpu_wr ? OP_WR : OP_RD;
            tgt_q     <= rom_sel ? TGT_ROM : TGT_RAM;
            err_q     <= illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if (capture) begin
            cpu_rdata <= (tgt_q == TGT_ROM) ? rom_rdata : ram_rdata;
        end
    end

    assign ram_ena   = (state == ACCESS) && (tgt_q == TGT_RAM);
    assign ram_read  = ram_ena && (op_q == OP_RD);
    assign ram_write = ram_ena && (op_q == OP_WR);
    assign rom_ena   = (state == ACCESS) && (tgt_q == TGT_ROM);
    assign rom_read  = rom_ena && (op_q == OP_RD);
    assign cpu_ready = (state == RESP);
    assign bus_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// tb/tb_mem_resp_ctrl.sv - self-checking bench for mem_resp_ctrl with RAM/ROM models and a shadow reference
module tb_mem_resp_ctrl;

    localparam int RAM_WAIT = 0;
    localparam int ROM_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd, cpu_wr, ram_sel, rom_sel;
    logic [12:0] addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  ram_rdata, rom_rdata;
    logic        ram_ena, ram_read, ram_write, rom_ena, rom_read;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, cpu_rdata;
    logic        cpu_ready, bus_err;

    logic [7:0]  ram_mem [0:8191];
    logic [7:0]  rom_mem [0:8191];
    logic [7:0]  shadow  [0:8191];
    logic [7:0]  model_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_resp_ctrl #(
        .ADDR_W   (13),
        .DATA_W   (8),
        .RAM_WAIT (RAM_WAIT),
        .ROM_WAIT (ROM_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .addr      (addr),
        .cpu_wdata (cpu_wdata),
        .ram_sel   (ram_sel),
        .rom_sel   (rom_sel),
        .ram_rdata (ram_rdata),
        .rom_rdata (rom_rdata),
        .ram_ena   (ram_ena),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rom_ena   (rom_ena),
        .rom_read  (rom_read),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_err   (bus_err)
    );

    assign ram_rdata = (ram_ena && ram_read) ? ram_mem[mem_addr] : 8'hEE;
    assign rom_rdata = (rom_ena && rom_read) ? rom_mem[mem_addr] : 8'hEE;

    always @(posedge clk) begin
        if (ram_ena && ram_write) ram_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Runs one request and measures it; strobe/addr/pulse-width deviations are counted in bad.
    task automatic run_txn(input logic rd, input logic wr, input logic rs, input logic os,
                           input logic [12:0] a, input logic [7:0] wd,
                           input logic legal, input logic to_ram, input int wt,
                           output int lat, output logic err, output int bad);
        logic act;
        lat = -1; err = 1'b0; bad = 0;
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; ram_sel = rs; rom_sel = os; addr = a; cpu_wdata = wd;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                cpu_rd = 1'b0; cpu_wr = 1'b0; addr = ~a; cpu_wdata = ~wd;
                ram_sel = 1'($urandom); rom_sel = 1'($urandom);
            end
            act = legal && (k <= wt + 1);
            if (ram_ena !== (act && to_ram) || ram_read !== (act && to_ram && rd) ||
                ram_write !== (act && to_ram && wr) || rom_ena !== (act && !to_ram) ||
                rom_read !== (act && !to_ram)) bad++;
            if (act && mem_addr !== a) bad++;
            if (act && wr && mem_wdata !== wd) bad++;
            if (cpu_ready === 1'b1) begin
                lat = k; err = bus_err;
                break;
            end
            if (bus_err !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        if (cpu_ready !== 1'b0 || bus_err !== 1'b0) bad++;
    endtask

    typedef struct {
        string       nm;
        logic        rd, wr, rs, os;
        logic [12:0] a;
        logic [7:0]  wd;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int   lat, bad, rdy;
        logic err, rd, wr, rs, os, illegal;
        logic [12:0] a;
        logic [7:0]  wd, exp_rd;

        for (int i = 0; i < 8192; i++) begin
            ram_mem[i] = 8'h00;
            shadow[i]  = 8'h00;
            rom_mem[i] = 8'(i * 7 + 3);
        end
        rom_mem[16'h0010] = 8'h3C;

        vecs[0] = '{"ram_wr_a5",   0, 1, 1, 0, 13'h1804, 8'hA5, 0, RAM_WAIT + 2, 8'h00};
        vecs[1] = '{"rom_rd_3c",   1, 0, 0, 1, 13'h0010, 8'h00, 0, ROM_WAIT + 2, 8'h3C};
        vecs[2] = '{"rom_wr_err",  0, 1, 0, 1, 13'h0100, 8'h77, 1, 1,            8'h3C};
        vecs[3] = '{"rd_wr_err",   1, 1, 1, 0, 13'h1804, 8'h11, 1, 1,            8'h3C};
        vecs[4] = '{"both_sel",    1, 0, 1, 1, 13'h1804, 8'h00, 1, 1,            8'h3C};
        vecs[5] = '{"no_sel",      1, 0, 0, 0, 13'h1804, 8'h00, 1, 1,            8'h3C};
        vecs[6] = '{"ram_rd_a5",   1, 0, 1, 0, 13'h1804, 8'h00, 0, RAM_WAIT + 2, 8'hA5};
        vecs[7] = '{"ram_wr_5a",   0, 1, 1, 0, 13'h1805, 8'h5A, 0, RAM_WAIT + 2, 8'hA5};
        vecs[8] = '{"ram_rd_5a",   1, 0, 1, 0, 13'h1805, 8'h00, 0, RAM_WAIT + 2, 8'h5A};

        cpu_rd = 0; cpu_wr = 0; ram_sel = 0; rom_sel = 0; addr = '0; cpu_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {31'd0, ram_ena | ram_read | ram_write | rom_ena | rom_read}, 0);
        chk("reset_resp", {30'd0, cpu_ready, bus_err}, 0);
        chk("reset_rdata", {24'd0, cpu_rdata}, 0);
        chk("reset_addr", {11'd0, mem_addr, mem_wdata}, 0);
        @(negedge clk) rst_n = 1'b1;
        model_rdata = 8'h00;

        foreach (vecs[i]) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].os, vecs[i].a, vecs[i].wd,
                    !vecs[i].exp_err, vecs[i].rs, vecs[i].exp_lat - 2, lat, err, bad);
            chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].nm, "_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].nm, "_rdata"}, {24'd0, cpu_rdata}, {24'd0, vecs[i].exp_rdata});
            chk({vecs[i].nm, "_strobes"}, 32'(bad), 0);
            if (!vecs[i].exp_err && vecs[i].wr) shadow[vecs[i].a] = vecs[i].wd;
            model_rdata = vecs[i].exp_rdata;
        end

        // A second read held during ACCESS must be dropped.
        @(negedge clk);
        cpu_rd = 1; ram_sel = 0; rom_sel = 1; addr = 13'h0010;
        rdy = 0; lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 3) cpu_rd = 0;
            if (cpu_ready === 1'b1) begin
                rdy++;
                if (lat < 0) lat = k;
            end
        end
        chk("ignored_rd_ready_count", 32'(rdy), 1);
        chk("ignored_rd_lat", 32'(lat), 32'(ROM_WAIT + 2));
        chk("ignored_rd_rdata", {24'd0, cpu_rdata}, {24'd0, rom_mem[16]});

        // Reset two edges into a ROM read aborts it.
        @(negedge clk);
        cpu_rd = 1; ram_sel = 0; rom_sel = 1; addr = 13'h0020;
        @(posedge clk); #1 cpu_rd = 0;
        @(posedge clk); #1;
        chk("abort_rom_active", {31'd0, rom_read}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {ram_ena, ram_read, ram_write, rom_ena, rom_read, cpu_ready, bus_err, 25'd0} | 32'(cpu_rdata) | 32'(mem_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (cpu_ready === 1'b1) rdy++;
        end
        chk("abort_no_ready", 32'(rdy), 0);
        model_rdata = 8'h00;

        for (int n = 0; n < 40; n++) begin
            int r;
            r  = $urandom_range(0, 9);
            rd = 1'($urandom);
            wr = (r == 0) ? 1'b1 : !rd;
            if (r == 0) rd = 1'b1;
            if (r == 1) begin rs = 1; os = 1; end
            else if (r == 2) begin rs = 0; os = 0; end
            else begin rs = 1'($urandom); os = !rs; end
            a  = 13'($urandom_range(0, 7)) | (rs ? 13'h1800 : 13'h0000);
            wd = 8'($urandom);
            illegal = (rd && wr) || (rs == os) || (wr && os);
            exp_rd = model_rdata;
            if (!illegal && rd) exp_rd = rs ? shadow[a] : rom_mem[a];
            run_txn(rd, wr, rs, os, a, wd, !illegal, rs, rs ? RAM_WAIT : ROM_WAIT, lat, err, bad);
            chk("rand_lat", 32'(lat), illegal ? 1 : 32'((rs ? RAM_WAIT : ROM_WAIT) + 2));
            chk("rand_err", {31'd0, err}, {31'd0, illegal});
            chk("rand_rdata", {24'd0, cpu_rdata}, {24'd0, exp_rd});
            chk("rand_strobes", 32'(bad), 0);
            model_rdata = exp_rd;
            if (!illegal && wr) shadow[a] = wd;
        end

        for (int n = 0; n < 4; n++) begin
            a = 13'h1800 + 13'(n);
            run_txn(1, 0, 1, 0, a, 8'h00, 1, 1, RAM_WAIT, lat, err, bad);
            chk("b2b_lat", 32'(lat), 32'(RAM_WAIT + 2));
            chk("b2b_rdata", {24'd0, cpu_rdata}, {24'd0, shadow[a]});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
